// File: rtl/ucc8_sequencer.sv
// ucc8_sequencer: command initiator for the UCC8 counter/register.
// Loads a start value into the counter, checks the load, counts N steps
// up or down and reports the final value together with wrap/load status.
module ucc8_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH-1:0] ticks,
  input  logic [WIDTH-1:0] ucc_q,
  input  logic             ucc_co,
  output logic [WIDTH-1:0] ucc_pin,
  output logic [1:0]       ucc_min,
  output logic             ucc_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             wrapped,
  output logic             load_err
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] sval_q, sval_d;
  logic [WIDTH-1:0] ticks_q, ticks_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             wrapped_q, wrapped_d;
  logic             load_err_q, load_err_d;
  logic [1:0]       min_q, min_d;
  logic             cin_q, cin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] pin_q, pin_d;

  // Next-state logic; counter-facing outputs are decoded from the next state
  // so that the registered copies line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    sval_d     = sval_q;
    ticks_d    = ticks_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    wrapped_d  = wrapped_q;
    load_err_d = load_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dir_d      = dir;
          sval_d     = start_val;
          ticks_d    = ticks;
          wrapped_d  = 1'b0;
          load_err_d = 1'b0;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (ucc_q != sval_q) begin
          load_err_d = 1'b1;
          state_d    = ST_DONE;
        end else if (ticks_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = ticks_q;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (ucc_co) begin
          wrapped_d = 1'b1;
        end
        cnt_d = cnt_q - WIDTH'(1);
        if (cnt_q == WIDTH'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        result_d = ucc_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    min_d  = MODE_HOLD;
    cin_d  = 1'b0;
    pin_d  = sval_d;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    if (state_d == ST_LOAD) begin
      min_d = MODE_LOAD;
    end else if (state_d == ST_COUNT) begin
      min_d = dir_d ? MODE_UP : MODE_DOWN;
      cin_d = 1'b1;
    end
  end

  // State, captured job parameters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      sval_q     <= '0;
      ticks_q    <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      wrapped_q  <= 1'b0;
      load_err_q <= 1'b0;
      min_q      <= MODE_HOLD;
      cin_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pin_q      <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      sval_q     <= sval_d;
      ticks_q    <= ticks_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      wrapped_q  <= wrapped_d;
      load_err_q <= load_err_d;
      min_q      <= min_d;
      cin_q      <= cin_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pin_q      <= pin_d;
    end
  end

  assign ucc_pin  = pin_q;
  assign ucc_min  = min_q;
  assign ucc_cin  = cin_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign wrapped  = wrapped_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_ucc8_sequencer.sv
// Directed bench for ucc8_sequencer with a behavioural UCC8 counter attached.
`timescale 1ns/1ps
module tb_ucc8_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       dir;
  logic [7:0] start_val;
  logic [7:0] ticks;
  logic [7:0] ucc_q;
  logic       ucc_co;
  logic [7:0] ucc_pin;
  logic [1:0] ucc_min;
  logic       ucc_cin;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       wrapped;
  logic       load_err;

  int errors = 0;
  int checks = 0;

  // Behavioural counter: hold / down / up / parallel load, cin gates counting.
  logic [7:0] cnt_model = 8'h00;
  bit         force_q   = 1'b0;
  logic [7:0] force_val = 8'h00;

  assign ucc_q  = force_q ? force_val : cnt_model;
  assign ucc_co = ucc_cin && ((ucc_min == 2'b10 && ucc_q == 8'hFF) ||
                              (ucc_min == 2'b01 && ucc_q == 8'h00));

  always @(posedge clk) begin
    case (ucc_min)
      2'b11: cnt_model <= ucc_pin;
      2'b10: if (ucc_cin) cnt_model <= cnt_model + 8'd1;
      2'b01: if (ucc_cin) cnt_model <= cnt_model - 8'd1;
      default: ;
    endcase
  end

  always #5 clk = ~clk;

  ucc8_sequencer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dir      (dir),
    .start_val(start_val),
    .ticks    (ticks),
    .ucc_q    (ucc_q),
    .ucc_co   (ucc_co),
    .ucc_pin  (ucc_pin),
    .ucc_min  (ucc_min),
    .ucc_cin  (ucc_cin),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .wrapped  (wrapped),
    .load_err (load_err)
  );

  // Launch one job from IDLE and observe it at negedges. lat counts negedges
  // after the accepting edge (k=0 is the LOAD cycle), so done appears at
  // k = ticks+2, or k = 2 when no counting happens.
  task automatic run_job(input logic d, input logic [7:0] sv, input logic [7:0] tk,
                         output int lat, output int cnt_cycles, output bit saw_load,
                         output bit saw_cin, output bit w, output bit le,
                         output logic [7:0] res, output bit timeout);
    lat = -1; cnt_cycles = 0; saw_load = 0; saw_cin = 0; w = 0; le = 0;
    timeout = 1; res = 8'h00;
    @(negedge clk);
    start = 1'b1; dir = d; start_val = sv; ticks = tk;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (ucc_min == 2'b11 && ucc_pin == sv) saw_load = 1;
      if (ucc_cin) saw_cin = 1;
      if (ucc_cin && ucc_min == (d ? 2'b10 : 2'b01)) cnt_cycles++;
      if (done) begin
        lat = k; w = wrapped; le = load_err; timeout = 0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dir = 1'b0; start_val = 8'h00; ticks = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) rst = 1'b0;
      checks++;
      if ({ucc_min, ucc_cin, busy, done, result} !== 13'h0) begin
        errors++;
        $display("FAIL reset[%0d]: min=%b cin=%b busy=%b done=%b result=%h, required all zero",
                 i, ucc_min, ucc_cin, busy, done, result);
      end
    end
  endtask

  task automatic test_up_no_wrap();
    int lat, cc; bit sl, sc, w, le, to; logic [7:0] res;
    run_job(1'b1, 8'hF0, 8'd5, lat, cc, sl, sc, w, le, res, to);
    checks++; if (to) begin errors++; $display("FAIL up_no_wrap timeout: no done within bound"); end
    checks++; if (lat !== 7) begin errors++; $display("FAIL up_no_wrap latency: got %0d, required 7", lat); end
    checks++; if (sl !== 1'b1) begin errors++; $display("FAIL up_no_wrap load: LOAD with pin=F0 seen=%b, required 1", sl); end
    checks++; if (cc !== 5) begin errors++; $display("FAIL up_no_wrap count_cycles: got %0d, required 5", cc); end
    checks++; if (res !== 8'hF5) begin errors++; $display("FAIL up_no_wrap result: got %h, required f5", res); end
    checks++; if ({w, le} !== 2'b00) begin errors++; $display("FAIL up_no_wrap flags: wrapped=%b load_err=%b, required 0 0", w, le); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_no_wrap busy_after: got %b, required 0", busy); end
  endtask

  task automatic test_up_wrap();
    int lat, cc; bit sl, sc, w, le, to; logic [7:0] res;
    run_job(1'b1, 8'hFE, 8'd3, lat, cc, sl, sc, w, le, res, to);
    checks++; if (to || lat !== 5) begin errors++; $display("FAIL up_wrap latency: got %0d, required 5", lat); end
    checks++; if (res !== 8'h01) begin errors++; $display("FAIL up_wrap result: got %h, required 01", res); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL up_wrap wrapped: got %b, required 1", w); end
  endtask

  task automatic test_down_wrap();
    int lat, cc; bit sl, sc, w, le, to; logic [7:0] res;
    run_job(1'b0, 8'h01, 8'd2, lat, cc, sl, sc, w, le, res, to);
    checks++; if (to || lat !== 4) begin errors++; $display("FAIL down_wrap latency: got %0d, required 4", lat); end
    checks++; if (cc !== 2) begin errors++; $display("FAIL down_wrap count_cycles: got %0d, required 2", cc); end
    checks++; if (res !== 8'hFF) begin errors++; $display("FAIL down_wrap result: got %h, required ff", res); end
    checks++; if (w !== 1'b1) begin errors++; $display("FAIL down_wrap wrapped: got %b, required 1", w); end
  endtask

  task automatic test_zero_ticks();
    int lat, cc; bit sl, sc, w, le, to; logic [7:0] res;
    run_job(1'b1, 8'hFF, 8'd0, lat, cc, sl, sc, w, le, res, to);
    checks++; if (to || lat !== 2) begin errors++; $display("FAIL zero_ticks latency: got %0d, required 2", lat); end
    checks++; if (sc !== 1'b0) begin errors++; $display("FAIL zero_ticks cin: cin seen=%b, required 0", sc); end
    checks++; if (res !== 8'hFF) begin errors++; $display("FAIL zero_ticks result: got %h, required ff", res); end
    checks++; if ({w, le} !== 2'b00) begin errors++; $display("FAIL zero_ticks flags: wrapped=%b load_err=%b, required 0 0", w, le); end
  endtask

  task automatic test_load_err();
    int lat, cc; bit sl, sc, w, le, to; logic [7:0] res;
    force_q = 1'b1; force_val = 8'h00;
    run_job(1'b1, 8'h55, 8'd4, lat, cc, sl, sc, w, le, res, to);
    force_q = 1'b0;
    checks++; if (to || lat !== 2) begin errors++; $display("FAIL load_err latency: got %0d, required 2", lat); end
    checks++; if (le !== 1'b1) begin errors++; $display("FAIL load_err flag: got %b, required 1", le); end
    checks++; if (sc !== 1'b0) begin errors++; $display("FAIL load_err cin: cin seen=%b, required 0", sc); end
    checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL load_err hold: got %b, required 1", load_err); end
  endtask

  task automatic test_busy_start();
    int lat = -1; int busy_after = 0;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; start_val = 8'h10; ticks = 8'd6;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (k == 4) begin start = 1'b1; dir = 1'b0; start_val = 8'h99; ticks = 8'd1; end
      if (k == 5) start = 1'b0;
      if (done) begin lat = k; break; end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (lat !== 8) begin errors++; $display("FAIL busy_start latency: got %0d, required 8", lat); end
    @(negedge clk);
    checks++; if (result !== 8'h16) begin errors++; $display("FAIL busy_start result: got %h, required 16", result); end
    for (int i = 0; i < 6; i++) begin
      if (busy) busy_after++;
      @(negedge clk);
    end
    checks++; if (busy_after !== 0) begin errors++; $display("FAIL busy_start queued_job: busy cycles=%0d, required 0", busy_after); end
  endtask

  task automatic test_reset_mid();
    int dones = 0; int busies = 0;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; start_val = 8'h20; ticks = 8'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ucc_cin !== 1'b1) begin errors++; $display("FAIL reset_mid in_count: cin=%b, required 1", ucc_cin); end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, ucc_min, ucc_cin, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid immediate: busy=%b min=%b cin=%b done=%b, required 0 00 0 0",
               busy, ucc_min, ucc_cin, done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL reset_mid done_pulses: got %0d, required 0", dones); end
    checks++; if (busies !== 0) begin errors++; $display("FAIL reset_mid busy_after: got %0d, required 0", busies); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    @(negedge clk);
    start = 1'b1; dir = 1'b1; start_val = 8'h30; ticks = 8'd1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    checks++; if (dones !== 4) begin errors++; $display("FAIL back_to_back done_pulses: got %0d, required 4", dones); end
    checks++; if (result !== 8'h31) begin errors++; $display("FAIL back_to_back result: got %h, required 31", result); end
  endtask

  initial begin
    test_reset();
    test_up_no_wrap();
    test_up_wrap();
    test_down_wrap();
    test_zero_ticks();
    test_load_err();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
